// File: rtl/io_dma_sched_if.sv
// Bus bundle for io_dma_sched: config slave, peripheral source, hub datapath controls and irq.
// The slave modport is the controller's view; master is the surrounding system's view.
interface io_dma_sched_if;
    logic        cfg_stb_i;
    logic        cfg_we_i;
    logic [1:0]  cfg_addr_i;
    logic [31:0] cfg_data_i;
    logic        cfg_ack_o;
    logic [31:0] cfg_data_o;
    logic        src_valid_i;
    logic [31:0] src_data_i;
    logic        src_ready_o;
    logic [31:0] hub_data_o;
    logic [31:0] hub_status_o;
    logic [31:0] hub_addr_first_o;
    logic [31:0] hub_addr_end_o;
    logic        hub_dma_stb_i;
    logic        hub_dma_ack_i;
    logic        irq_o;

    modport slave (
        input  cfg_stb_i, cfg_we_i, cfg_addr_i, cfg_data_i,
        input  src_valid_i, src_data_i, hub_dma_stb_i, hub_dma_ack_i,
        output cfg_ack_o, cfg_data_o, src_ready_o, hub_data_o, hub_status_o,
        output hub_addr_first_o, hub_addr_end_o, irq_o
    );

    modport master (
        output cfg_stb_i, cfg_we_i, cfg_addr_i, cfg_data_i,
        output src_valid_i, src_data_i, hub_dma_stb_i, hub_dma_ack_i,
        input  cfg_ack_o, cfg_data_o, src_ready_o, hub_data_o, hub_status_o,
        input  hub_addr_first_o, hub_addr_end_o, irq_o
    );
endinterface

// File: rtl/io_dma_sched.sv
// io_dma_sched: sequences the I/O hub FIFO-to-DMA datapath. Alternates FILL bursts (source words
// pushed into the hub FIFO) with DRAIN bursts (hub DMA acks), counts beats and raises an irq.
// Optional drain watchdog enabled by defining IO_DMA_SCHED_WDT_EN.
module io_dma_sched #(
    parameter int unsigned FIFO_DEPTH = 8
`ifdef IO_DMA_SCHED_WDT_EN
    , parameter int unsigned WDT_CYCLES = 1024
`endif
) (
    input logic           clk,
    input logic           rst_n,
    io_dma_sched_if.slave bus
);
    localparam int unsigned OccW = $clog2(FIFO_DEPTH + 1);
    localparam logic [OccW-1:0] DepthOcc = OccW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StFill, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic            ack_q, wr_pend_q;
    logic [1:0]      wr_addr_q;
    logic [31:0]     wr_data_q, rdata_q, rd_mux;
    logic            irq_en_q, done_q, err_q;
    logic [31:0]     addr_first_q, addr_end_q;
    logic [16:0]     pushed_q, len;
    logic [15:0]     beats_q;
    logic [OccW-1:0] occ_q;
    logic            req, busy, bad_range;
    logic            ctrl_wr, start, abort;
    logic            src_ready, push, drain_en, ack, dec, go, bad_start, spurious, wdt_trip;

    assign req       = bus.cfg_stb_i & ~ack_q;
    assign busy      = (state_q != StIdle);
    assign len       = {1'b0, addr_end_q[15:0]} - {1'b0, addr_first_q[15:0]} + 17'd1;
    assign bad_range = addr_end_q[15:0] < addr_first_q[15:0];
    // wr_pend_q is high exactly during the ack cycle; the write lands on the edge that ends it.
    assign ctrl_wr   = wr_pend_q && (wr_addr_q == 2'd0);
    assign abort     = ctrl_wr & wr_data_q[2];
    assign start     = ctrl_wr & wr_data_q[0] & ~wr_data_q[2];
    assign ack       = bus.hub_dma_ack_i;
    assign spurious  = ack && (occ_q == '0);
    assign dec       = (state_q == StDrain) && ack && (occ_q != '0);

`ifdef IO_DMA_SCHED_WDT_EN
    localparam int unsigned WdtW = $clog2(WDT_CYCLES + 1);
    logic [WdtW-1:0] wdt_q;

    // Cycles since the last ack while draining; cleared outside DRAIN so entry starts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_q <= '0;
        end else if (state_q != StDrain || ack) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_q + 1'b1;
        end
    end

    assign wdt_trip = (state_q == StDrain) && !ack && (wdt_q == WdtW'(WDT_CYCLES - 1));
`else
    assign wdt_trip = 1'b0;
`endif

    // Next-state and datapath strobes.
    always_comb begin
        state_d   = state_q;
        src_ready = 1'b0;
        push      = 1'b0;
        drain_en  = 1'b0;
        go        = 1'b0;
        bad_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && bad_range) begin
                    bad_start = 1'b1;
                end else if (start) begin
                    go      = 1'b1;
                    state_d = StFill;
                end
            end
            StFill: begin
                src_ready = (occ_q < DepthOcc) && (pushed_q < len);
                push      = src_ready & bus.src_valid_i;
                if ((occ_q + OccW'(push)) == DepthOcc || (pushed_q + 17'(push)) == len) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                drain_en = 1'b1;
                if (wdt_trip) begin
                    state_d = StIdle;
                end else if (dec && occ_q == OccW'(1)) begin
                    state_d = (pushed_q == len) ? StDone : StFill;
                end
            end
            StDone: state_d = StIdle;
        endcase
        if (abort) state_d = StIdle;
    end

    // Read mux, evaluated on the strobe cycle.
    always_comb begin
        rd_mux = '0;
        unique case (bus.cfg_addr_i)
            2'd0: rd_mux = {30'd0, irq_en_q, 1'b0};
            2'd1: rd_mux = addr_first_q;
            2'd2: rd_mux = addr_end_q;
            2'd3: rd_mux = {beats_q, 13'd0, err_q, done_q, busy};
        endcase
    end

    // Config handshake: one-cycle registered ack, request captured on the strobe cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q     <= 1'b0;
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rdata_q   <= '0;
        end else begin
            ack_q     <= req;
            wr_pend_q <= req & bus.cfg_we_i;
            if (req) begin
                wr_addr_q <= bus.cfg_addr_i;
                wr_data_q <= bus.cfg_data_i;
                rdata_q   <= rd_mux;
            end
        end
    end

    // Programmed registers and sticky flags; a flag-setting event beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_q     <= 1'b0;
            addr_first_q <= '0;
            addr_end_q   <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en_q <= wr_data_q[1];
            if (wr_pend_q && wr_addr_q == 2'd1 && !busy) addr_first_q <= wr_data_q;
            if (wr_pend_q && wr_addr_q == 2'd2 && !busy) addr_end_q <= wr_data_q;
            if (state_q == StDone) done_q <= 1'b1;
            else if (go || (wr_pend_q && wr_addr_q == 2'd3)) done_q <= 1'b0;
            if (bad_start || spurious || wdt_trip) err_q <= 1'b1;
            else if (wr_pend_q && wr_addr_q == 2'd3) err_q <= 1'b0;
        end
    end

    // State register and transfer counters; counters hold across abort for readback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pushed_q <= '0;
            beats_q  <= '0;
            occ_q    <= '0;
        end else begin
            state_q <= state_d;
            if (go) begin
                pushed_q <= '0;
                beats_q  <= '0;
                occ_q    <= '0;
            end else if (push) begin
                pushed_q <= pushed_q + 17'd1;
                occ_q    <= occ_q + 1'b1;
            end else if (dec) begin
                occ_q   <= occ_q - 1'b1;
                beats_q <= beats_q + 16'd1;
            end
        end
    end

    assign bus.cfg_ack_o        = ack_q;
    assign bus.cfg_data_o       = rdata_q;
    assign bus.src_ready_o      = src_ready;
    assign bus.hub_data_o       = bus.src_data_i;
    assign bus.hub_status_o     = {29'd0, push, drain_en, busy};
    assign bus.hub_addr_first_o = addr_first_q;
    assign bus.hub_addr_end_o   = addr_end_q;
    assign bus.irq_o            = irq_en_q & (done_q | err_q);
endmodule

// File: tb/tb_io_dma_sched.sv
// Scoreboard bench for io_dma_sched: expected fill bursts and read data are queued when stimulus
// is issued and compared when the DUT produces them; a hub model acks drained words.
module tb_io_dma_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    io_dma_sched_if bus();

    io_dma_sched #(
        .FIFO_DEPTH(8)
`ifdef IO_DMA_SCHED_WDT_EN
        , .WDT_CYCLES(16)
`endif
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int exp_burst[$];
    logic [31:0] exp_rd[$];
    int fill_cnt = 0, model_cnt = 0, max_occ = 0, tot_push = 0;
    bit in_drain = 0, ack_en = 1, spur_req = 0;
    logic [31:0] next_word = 32'h100;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cfg_access(input logic we, input logic [1:0] addr, input logic [31:0] data);
        bit got = 0;
        @(negedge clk);
        bus.cfg_stb_i  = 1'b1;
        bus.cfg_we_i   = we;
        bus.cfg_addr_i = addr;
        bus.cfg_data_i = data;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.cfg_ack_o) begin
                got = 1;
                break;
            end
        end
        bus.cfg_stb_i = 1'b0;
        if (!got) check("cfg_ack_timeout", bus.cfg_ack_o, 32'd1);
        else if (!we) begin
            if (exp_rd.size() > 0) check("cfg_read", bus.cfg_data_o, exp_rd.pop_front());
        end
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
        cfg_access(1'b1, addr, data);
    endtask

    task automatic cfg_read(input logic [1:0] addr, input logic [31:0] exp);
        exp_rd.push_back(exp);
        cfg_access(1'b0, addr, 32'd0);
    endtask

    task automatic wait_irq();
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            if (bus.irq_o) break;
        end
        check("irq_wait", bus.irq_o, 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.hub_status_o[1]) break;
        end
        check("drain_wait", bus.hub_status_o[1], 32'd1);
    endtask

    // Hub model: observes pushes, checks burst sizes at DRAIN entry, acks one word per cycle.
    always @(negedge clk) begin
        bit drv;
        if (!rst_n) begin
            model_cnt = 0;
            fill_cnt  = 0;
            in_drain  = 0;
            exp_burst.delete();
            bus.hub_dma_stb_i = 1'b0;
            bus.hub_dma_ack_i = 1'b0;
        end else begin
            if (bus.hub_status_o[2]) begin
                check("push_data", bus.hub_data_o, next_word);
                next_word = next_word + 32'd1;
                bus.src_data_i = next_word;
                fill_cnt++;
                model_cnt++;
                tot_push++;
                if (model_cnt > max_occ) max_occ = model_cnt;
            end
            if (bus.hub_status_o[1] && !in_drain) begin
                in_drain = 1;
                if (exp_burst.size() > 0) check("fill_burst", fill_cnt, exp_burst.pop_front());
                else check("fill_burst_unexpected", fill_cnt, 32'd0);
                fill_cnt = 0;
            end else if (!bus.hub_status_o[1]) begin
                in_drain = 0;
            end
            drv = (bus.hub_status_o[1] && ack_en && model_cnt > 0) || spur_req;
            if (drv && !spur_req) model_cnt--;
            spur_req = 0;
            bus.hub_dma_stb_i = drv;
            bus.hub_dma_ack_i = bus.hub_dma_stb_i;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int tp;
        bus.cfg_stb_i = 0; bus.cfg_we_i = 0; bus.cfg_addr_i = 0; bus.cfg_data_i = 0;
        bus.src_valid_i = 0; bus.src_data_i = next_word;
        bus.hub_dma_stb_i = 0; bus.hub_dma_ack_i = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_status", bus.hub_status_o, 32'd0);
        check("rst_ready", bus.src_ready_o, 32'd0);
        check("rst_irq", bus.irq_o, 32'd0);
        check("rst_ack", bus.cfg_ack_o, 32'd0);
        check("rst_rdata", bus.cfg_data_o, 32'd0);
        check("rst_first", bus.hub_addr_first_o, 32'd0);
        check("rst_end", bus.hub_addr_end_o, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        cfg_read(2'd3, 32'd0);

        // Basic transfer of 5 words
        bus.src_valid_i = 1'b1;
        cfg_write(2'd1, 32'h10);
        cfg_write(2'd2, 32'h14);
        cfg_write(2'd0, 32'h2);
        check("addr_first_out", bus.hub_addr_first_o, 32'h10);
        check("addr_end_out", bus.hub_addr_end_o, 32'h14);
        cfg_read(2'd0, 32'h2);
        exp_burst.push_back(5);
        cfg_write(2'd0, 32'h3);
        check("start_ack_idle", bus.src_ready_o, 32'd0);
        @(posedge clk);
        #1;
        check("fill_busy", bus.hub_status_o[0], 32'd1);
        check("first_push_ready", bus.src_ready_o, 32'd1);
        wait_irq();
        cfg_read(2'd3, 32'h0005_0002);
        cfg_write(2'd3, 32'd0);
        @(posedge clk);
        #1;
        check("irq_cleared", bus.irq_o, 32'd0);
        cfg_read(2'd3, 32'h0005_0000);

        // FIFO saturation: 20 words in bursts of 8, 8, 4
        max_occ = 0;
        cfg_write(2'd1, 32'd0);
        cfg_write(2'd2, 32'd19);
        exp_burst.push_back(8); exp_burst.push_back(8); exp_burst.push_back(4);
        cfg_write(2'd0, 32'h3);
        wait_irq();
        cfg_read(2'd3, 32'h0014_0002);
        check("max_occ", max_occ, 32'd8);
        check("burst_queue_empty", exp_burst.size(), 32'd0);
        cfg_write(2'd3, 32'd0);

        // Spurious ack with empty FIFO sets error
        spur_req = 1;
        repeat (3) @(posedge clk);
        #1;
        cfg_read(2'd3, 32'h0014_0004);
        check("spur_irq", bus.irq_o, 32'd1);
        cfg_write(2'd3, 32'd0);

        // Bad range, with and without IRQ_EN
        tp = tot_push;
        cfg_write(2'd1, 32'd5);
        cfg_write(2'd2, 32'd4);
        cfg_write(2'd0, 32'h3);
        repeat (3) @(posedge clk);
        #1;
        check("bad_status_out", bus.hub_status_o, 32'd0);
        check("bad_irq_en", bus.irq_o, 32'd1);
        cfg_read(2'd3, 32'h0014_0004);
        check("bad_no_push", tot_push, tp);
        cfg_write(2'd3, 32'd0);
        cfg_write(2'd0, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        cfg_read(2'd3, 32'h0014_0004);
        check("bad_irq_dis", bus.irq_o, 32'd0);
        cfg_write(2'd3, 32'd0);
        cfg_write(2'd0, 32'h2);

        // Abort mid-FILL after 3 pushes
        bus.src_valid_i = 1'b0;
        cfg_write(2'd1, 32'd0);
        cfg_write(2'd2, 32'd19);
        cfg_write(2'd0, 32'h3);
        bus.src_valid_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        bus.src_valid_i = 1'b0;
        check("abort_pushes", fill_cnt, 32'd3);
        cfg_write(2'd0, 32'h6);
        check("pre_abort_ready", bus.src_ready_o, 32'd1);
        @(posedge clk);
        #1;
        check("abort_status", bus.hub_status_o, 32'd0);
        check("abort_ready", bus.src_ready_o, 32'd0);
        cfg_read(2'd3, 32'd0);
        fill_cnt = 0;
        model_cnt = 0;
        bus.src_valid_i = 1'b1;

`ifdef IO_DMA_SCHED_WDT_EN
        // Watchdog: withhold acks in DRAIN
        ack_en = 0;
        exp_burst.push_back(8);
        cfg_write(2'd0, 32'h3);
        wait_drain();
        cyc = 0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!bus.hub_status_o[0]) break;
        end
        check("wdt_cycles", cyc, 32'd16);
        check("wdt_status_out", bus.hub_status_o, 32'd0);
        cfg_read(2'd3, 32'h0000_0004);
        check("wdt_irq", bus.irq_o, 32'd1);
        cfg_write(2'd3, 32'd0);
        model_cnt = 0;
        ack_en = 1;
`endif

        // Async reset mid-DRAIN
        ack_en = 0;
        cfg_write(2'd1, 32'd2);
        cfg_write(2'd2, 32'd21);
        exp_burst.push_back(8);
        cfg_write(2'd0, 32'h3);
        wait_drain();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_status", bus.hub_status_o, 32'd0);
        check("arst_ready", bus.src_ready_o, 32'd0);
        check("arst_irq", bus.irq_o, 32'd0);
        check("arst_first", bus.hub_addr_first_o, 32'd0);
        check("arst_end", bus.hub_addr_end_o, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        ack_en = 1;
        cfg_read(2'd3, 32'd0);
        cfg_read(2'd0, 32'd0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
